// File: rtl/loadip_pkg.sv
// Shared definitions for the ping-pong buffer writer.
// Holds the FSM state encoding and the default idle timeout.
// No logic lives here.
package loadip_pkg;

  // Default number of data-less cycles before a partial buffer is committed
  localparam int IDLE_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/loadip_writer.sv
// Streams words into one of two ping-pong buffers, committing on frame end, full buffer or idle timeout.
// Latency: zero-cycle data/strobe path; claim one edge after valid data appears in IDLE.
// Backpressure: o_ready low outside WRITE and once the claimed buffer is full.
module loadip_writer
  import loadip_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic [1:0]            i_wr_ready,
  output logic [1:0]            o_wr_activate,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_wstrobe,
  input  logic [15:0]           i_wr_fifo_size,
  output logic [15:0]           o_last_cnt,
  output logic                  o_busy
);

  localparam logic [15:0] TIMEOUT = 16'(IDLE_TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  r_act;
  logic [15:0] r_count;
  logic [15:0] r_limit;
  logic [15:0] r_timer;
  logic [15:0] r_last_cnt;
  logic        r_next;

  logic        strobe;
  logic        claim;
  logic        rel;
  logic [1:0]  sel;
  logic [15:0] count_nxt;

  // Data path is purely combinational; the buffer sees the word in the cycle it is accepted
  assign o_ready       = (state == ST_WRITE) && (r_count < r_limit);
  assign strobe        = i_valid & o_ready;
  assign o_wstrobe     = strobe;
  assign o_wdata       = i_data;
  assign o_busy        = (state == ST_WRITE);
  assign o_wr_activate = r_act;
  assign o_last_cnt    = r_last_cnt;
  assign count_nxt     = r_count + {15'd0, strobe};

  // Claim only when there is data, a free buffer and a usable capacity
  assign claim = (state == ST_IDLE) && i_valid && (i_wr_ready != 2'b00)
              && (i_wr_fifo_size != 16'd0);

  // Commit on frame end, on filling the buffer, or after a data-less stretch with words pending
  assign rel = (state == ST_WRITE)
            && ((strobe && i_last) || (strobe && (count_nxt == r_limit))
                || ((r_timer == TIMEOUT) && (r_count != 16'd0)));

  // Buffer choice: the only free one, otherwise alternate via r_next
  always_comb begin
    sel = 2'b00;
    case (i_wr_ready)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = r_next ? 2'b10 : 2'b01;
      default: sel = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; RELEASE is a single cycle so activate is low for at least one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (claim) state_nxt = ST_WRITE;
      ST_WRITE:   if (rel)   state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Counters, claim and commit bookkeeping; reset discards any partial buffer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act      <= 2'b00;
      r_count    <= 16'd0;
      r_limit    <= 16'd0;
      r_timer    <= 16'd0;
      r_last_cnt <= 16'd0;
      r_next     <= 1'b0;
    end else if (claim) begin
      r_limit <= i_wr_fifo_size;
      r_count <= 16'd0;
      r_timer <= 16'd0;
      r_act   <= sel;
    end else if (state == ST_WRITE) begin
      r_count <= count_nxt;
      if (strobe)                r_timer <= 16'd0;
      else if (r_timer != TIMEOUT) r_timer <= r_timer + 16'd1;
      if (rel) begin
        r_act      <= 2'b00;
        r_last_cnt <= count_nxt;
        r_next     <= ~r_act[1];
      end
    end
  end

endmodule

// File: tb/tb_loadip_writer.sv
// Directed bench for loadip_writer: frame end, full buffer, idle timeout, no-free-buffer,
// reset mid-write, zero capacity and small-buffer cases, all with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs are sampled just after negedge.
module tb_loadip_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = 16'd0;
  logic        i_last = 1'b0;
  logic [1:0]  i_wr_ready = 2'b11;
  logic [1:0]  o_wr_activate;
  logic [15:0] o_wdata;
  logic        o_wstrobe;
  logic [15:0] i_wr_fifo_size = 16'd256;
  logic [15:0] o_last_cnt;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  int strb_cnt = 0;
  int dsum = 0;
  logic [1:0] act_at_strobe = 2'b00;

  loadip_writer #(.DATA_WIDTH(16), .IDLE_TIMEOUT(16)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_last         (i_last),
    .i_wr_ready     (i_wr_ready),
    .o_wr_activate  (o_wr_activate),
    .o_wdata        (o_wdata),
    .o_wstrobe      (o_wstrobe),
    .i_wr_fifo_size (i_wr_fifo_size),
    .o_last_cnt     (o_last_cnt),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Strobe monitor: counts accepted words, sums their data, remembers the active buffer
  always @(negedge i_clk) begin
    if (o_wstrobe) begin
      strb_cnt      = strb_cnt + 1;
      dsum          = dsum + int'(o_wdata);
      act_at_strobe = o_wr_activate;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    #1;
  endtask

  // Present one word and hold it until accepted; returns just after the accepting edge
  task automatic push(input logic [15:0] d, input logic l);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    @(negedge i_clk);
    while (!o_ready && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) chk("push_accept_timeout", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    int n;
    // ---------------- reset state, with upstream actively offering data
    i_valid = 1'b1;
    repeat (2) @(posedge i_clk);
    sample();
    chk("rst_activate", 32'(o_wr_activate), 32'd0);
    chk("rst_ready",    32'(o_ready),       32'd0);
    chk("rst_wstrobe",  32'(o_wstrobe),     32'd0);
    chk("rst_last_cnt", 32'(o_last_cnt),    32'd0);
    chk("rst_busy",     32'(o_busy),        32'd0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst   = 1'b0;

    // ---------------- 256 words, no last: fills the buffer, then next claim alternates
    strb_cnt = 0; dsum = 0;
    for (int k = 0; k < 256; k++) push(16'(k), 1'b0);
    chk("full_act", 32'(act_at_strobe), 32'd1);
    sample();
    chk("full_strobes",  32'(strb_cnt),      32'd256);
    chk("full_datasum",  32'(dsum),          32'd32640);
    chk("full_rel_act",  32'(o_wr_activate), 32'd0);
    chk("full_rel_rdy",  32'(o_ready),       32'd0);
    chk("full_last_cnt", 32'(o_last_cnt),    32'd256);
    push(16'h00aa, 1'b1);
    chk("alt_act", 32'(act_at_strobe), 32'd2);
    sample();
    chk("alt_last_cnt", 32'(o_last_cnt), 32'd1);

    // ---------------- 10-word frame ending with last
    strb_cnt = 0;
    for (int k = 1; k <= 10; k++) push(16'(k), k == 10);
    chk("frm_act_word10", 32'(act_at_strobe), 32'd1);
    sample();
    chk("frm_strobes",  32'(strb_cnt),      32'd10);
    chk("frm_act_drop", 32'(o_wr_activate), 32'd0);
    chk("frm_last_cnt", 32'(o_last_cnt),    32'd10);

    // ---------------- 5 words then idle: commit only after the timeout
    for (int k = 0; k < 5; k++) push(16'(k), 1'b0);
    repeat (15) sample();
    chk("idle_still_busy", 32'(o_busy), 32'd1);
    n = 0;
    while (o_busy && n < 10) begin
      sample();
      n++;
    end
    chk("idle_released", 32'(o_busy),     32'd0);
    chk("idle_last_cnt", 32'(o_last_cnt), 32'd5);

    // ---------------- no buffer free: stall, then claim buffer 1 when it frees
    strb_cnt   = 0;
    i_wr_ready = 2'b00;
    i_valid    = 1'b1;
    i_data     = 16'h1234;
    i_last     = 1'b1;
    repeat (4) sample();
    chk("nobuf_ready",   32'(o_ready),       32'd0);
    chk("nobuf_act",     32'(o_wr_activate), 32'd0);
    chk("nobuf_strobes", 32'(strb_cnt),      32'd0);
    @(posedge i_clk); #1;
    i_wr_ready = 2'b10;
    @(posedge i_clk); #1;
    chk("nobuf_claim", 32'(o_wr_activate), 32'd2);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    sample();
    chk("nobuf_strobes_after", 32'(strb_cnt),      32'd1);
    chk("nobuf_released",      32'(o_wr_activate), 32'd0);
    // Force buffer 0 so the alternation pointer points at buffer 1
    i_wr_ready = 2'b01;
    push(16'h0007, 1'b1);
    chk("only0_act", 32'(act_at_strobe), 32'd1);
    i_wr_ready = 2'b11;

    // ---------------- reset asserted while word 100 is being written
    for (int k = 0; k < 99; k++) push(16'(k), 1'b0);
    i_valid = 1'b1;
    i_data  = 16'd99;
    sample();
    chk("pre_rst_strobe", 32'(o_wstrobe),     32'd1);
    chk("pre_rst_act",    32'(o_wr_activate), 32'd2);
    i_rst = 1'b1;
    #1;
    chk("midrst_act",      32'(o_wr_activate), 32'd0);
    chk("midrst_ready",    32'(o_ready),       32'd0);
    chk("midrst_wstrobe",  32'(o_wstrobe),     32'd0);
    chk("midrst_busy",     32'(o_busy),        32'd0);
    chk("midrst_last_cnt", 32'(o_last_cnt),    32'd0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst   = 1'b0;
    push(16'h0055, 1'b1);
    chk("post_rst_act", 32'(act_at_strobe), 32'd1);

    // ---------------- zero capacity: never claims
    i_wr_fifo_size = 16'd0;
    i_valid = 1'b1;
    repeat (5) sample();
    chk("size0_busy", 32'(o_busy),        32'd0);
    chk("size0_act",  32'(o_wr_activate), 32'd0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;

    // ---------------- size 4 with last on word 4: one release
    i_wr_fifo_size = 16'd4;
    strb_cnt = 0;
    for (int k = 1; k <= 4; k++) push(16'(k), k == 4);
    sample();
    chk("sz4_rel_ready", 32'(o_ready),       32'd0);
    chk("sz4_rel_act",   32'(o_wr_activate), 32'd0);
    chk("sz4_last_cnt",  32'(o_last_cnt),    32'd4);
    chk("sz4_strobes",   32'(strb_cnt),      32'd4);
    repeat (3) sample();
    chk("sz4_single_rel", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
